// File: rtl/register_writeback_if.sv
// rtl/register_writeback_if.sv - execute/memory to register-file writeback port bundle
interface register_writeback_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_issue;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        write_enable;
  logic [4:0]  addr_rd;
  logic [31:0] data_rd;
  logic [31:0] busy;
  logic        ld_full;
  logic        protocol_err;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_issue, ld_rd, ld_funct3, ld_addr_lo,
    output mem_rvalid, mem_rdata,
    input  write_enable, addr_rd, data_rd, busy, ld_full, protocol_err
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_issue, ld_rd, ld_funct3, ld_addr_lo,
    input  mem_rvalid, mem_rdata,
    output write_enable, addr_rd, data_rd, busy, ld_full, protocol_err
  );
endinterface

// File: rtl/register_writeback.sv
// rtl/register_writeback.sv - in-order load queue, ALU/load write arbitration and busy scoreboard
module register_writeback #(
  parameter int DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  register_writeback_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = 1;

  logic [4:0]  rd_q     [DEPTH];
  logic [2:0]  funct3_q [DEPTH];
  logic [1:0]  addr_lo_q[DEPTH];
  logic [31:0] ldata_q  [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] filled_q, filled_d;

  logic [PW:0] alloc_q, alloc_d;
  logic [PW:0] fill_q, fill_d;
  logic [PW:0] retire_q, retire_d;

  logic        we_q, we_d;
  logic [4:0]  addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        err_q, err_d;

  logic [PW-1:0] alloc_idx, fill_idx, head_idx;
  logic          full;
  logic          alloc_ok, fill_ok, head_ready, retire_ok;
  logic [31:0]   busy_c;

  function automatic logic [31:0] format_load(input logic [2:0]  f3,
                                              input logic [1:0]  alo,
                                              input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (alo)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = alo[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'd0, b};
      3'b101:  r = {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  assign alloc_idx = alloc_q[PW-1:0];
  assign fill_idx  = fill_q[PW-1:0];
  assign head_idx  = retire_q[PW-1:0];

  // Full when indices match but wrap bits differ.
  assign full       = (alloc_q[PW] != retire_q[PW]) && (alloc_idx == head_idx);
  assign alloc_ok   = bus.ld_issue && !full;
  // Comparing against the registered alloc pointer keeps a same-cycle issue out of reach of fill.
  assign fill_ok    = bus.mem_rvalid && (fill_q != alloc_q);
  assign head_ready = valid_q[head_idx] && filled_q[head_idx];
  assign retire_ok  = !bus.alu_valid && head_ready;

  always_comb begin
    busy_c = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        busy_c[rd_q[i]] = 1'b1;
      end
    end
    busy_c[0] = 1'b0;
  end

  always_comb begin
    alloc_d  = alloc_q;
    fill_d   = fill_q;
    retire_d = retire_q;
    valid_d  = valid_q;
    filled_d = filled_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    err_d    = err_q;

    if (alloc_ok) begin
      valid_d[alloc_idx]  = 1'b1;
      filled_d[alloc_idx] = 1'b0;
      alloc_d             = alloc_q + PTR_ONE;
    end
    if (fill_ok) begin
      filled_d[fill_idx] = 1'b1;
      fill_d             = fill_q + PTR_ONE;
    end

    if (bus.alu_valid) begin
      we_d   = (bus.alu_rd != 5'd0);
      addr_d = bus.alu_rd;
      data_d = bus.alu_data;
    end else if (head_ready) begin
      we_d   = (rd_q[head_idx] != 5'd0);
      addr_d = rd_q[head_idx];
      data_d = format_load(funct3_q[head_idx], addr_lo_q[head_idx], ldata_q[head_idx]);
    end

    if (retire_ok) begin
      valid_d[head_idx]  = 1'b0;
      filled_d[head_idx] = 1'b0;
      retire_d           = retire_q + PTR_ONE;
    end

    if ((bus.ld_issue && full) || (bus.mem_rvalid && !fill_ok)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      alloc_q  <= '0;
      fill_q   <= '0;
      retire_q <= '0;
      valid_q  <= '0;
      filled_q <= '0;
      we_q     <= 1'b0;
      addr_q   <= 5'd0;
      data_q   <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      alloc_q  <= alloc_d;
      fill_q   <= fill_d;
      retire_q <= retire_d;
      valid_q  <= valid_d;
      filled_q <= filled_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      err_q    <= err_d;
    end
  end

  // Payload fields are qualified by valid/filled, so they need no reset.
  always_ff @(posedge clock) begin
    if (alloc_ok) begin
      rd_q[alloc_idx]      <= bus.ld_rd;
      funct3_q[alloc_idx]  <= bus.ld_funct3;
      addr_lo_q[alloc_idx] <= bus.ld_addr_lo;
    end
    if (fill_ok) begin
      ldata_q[fill_idx] <= bus.mem_rdata;
    end
  end

  assign bus.write_enable = we_q;
  assign bus.addr_rd      = addr_q;
  assign bus.data_rd      = data_q;
  assign bus.busy         = busy_c;
  assign bus.ld_full      = full;
  assign bus.protocol_err = err_q;
endmodule

// File: tb/tb_register_writeback.sv
// tb/tb_register_writeback.sv - directed self-checking bench for register_writeback
module tb_register_writeback;
  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  register_writeback_if bus ();

  register_writeback #(.DEPTH(4)) dut (
    .clock (clk),
    .reset (rstn),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.alu_valid  = 1'b0;
    bus.alu_rd     = 5'd0;
    bus.alu_data   = 32'd0;
    bus.ld_issue   = 1'b0;
    bus.ld_rd      = 5'd0;
    bus.ld_funct3  = 3'd0;
    bus.ld_addr_lo = 2'd0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] alo);
    bus.ld_issue   = 1'b1;
    bus.ld_rd      = rd;
    bus.ld_funct3  = f3;
    bus.ld_addr_lo = alo;
    tick();
    bus.ld_issue   = 1'b0;
  endtask

  task automatic load_fmt(input string tag, input logic [2:0] f3, input logic [1:0] alo,
                          input logic [31:0] exp);
    issue(5'd7, f3, alo);
    chk({tag, "_busy"}, bus.busy, 32'h0000_0080);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h12F4_5678;
    tick();
    bus.mem_rvalid = 1'b0;
    chk({tag, "_we_fill"}, {31'd0, bus.write_enable}, 32'd0);
    tick();
    chk({tag, "_we"}, {31'd0, bus.write_enable}, 32'd1);
    chk({tag, "_addr"}, {27'd0, bus.addr_rd}, 32'd7);
    chk({tag, "_data"}, bus.data_rd, exp);
    chk({tag, "_busy_clr"}, bus.busy, 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    do_reset();
    tick();

    chk("rst_we", {31'd0, bus.write_enable}, 32'd0);
    chk("rst_addr", {27'd0, bus.addr_rd}, 32'd0);
    chk("rst_data", bus.data_rd, 32'd0);
    chk("rst_busy", bus.busy, 32'd0);
    chk("rst_full", {31'd0, bus.ld_full}, 32'd0);
    chk("rst_err", {31'd0, bus.protocol_err}, 32'd0);

    // ALU only
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd5;
    bus.alu_data  = 32'hDEAD_BEEF;
    tick();
    bus.alu_valid = 1'b0;
    chk("alu_we", {31'd0, bus.write_enable}, 32'd1);
    chk("alu_addr", {27'd0, bus.addr_rd}, 32'd5);
    chk("alu_data", bus.data_rd, 32'hDEAD_BEEF);
    tick();
    chk("alu_we_off", {31'd0, bus.write_enable}, 32'd0);

    // Load formatting
    load_fmt("lb", 3'b000, 2'd2, 32'hFFFF_FFF4);
    load_fmt("lbu", 3'b100, 2'd2, 32'h0000_00F4);
    load_fmt("lhu", 3'b101, 2'd2, 32'h0000_12F4);
    load_fmt("lh", 3'b001, 2'd0, 32'h0000_5678);
    load_fmt("lw", 3'b010, 2'd2, 32'h12F4_5678);

    // Collision: filled head waits behind two ALU writes
    issue(5'd9, 3'b010, 2'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hAABB_CCDD;
    tick();
    bus.mem_rvalid = 1'b0;
    bus.alu_valid  = 1'b1;
    bus.alu_rd     = 5'd3;
    bus.alu_data   = 32'h1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("col_alu_we", {31'd0, bus.write_enable}, 32'd1);
      chk("col_alu_addr", {27'd0, bus.addr_rd}, 32'd3);
      chk("col_alu_data", bus.data_rd, 32'h1);
      chk("col_busy", bus.busy, 32'h0000_0200);
    end
    bus.alu_valid = 1'b0;
    tick();
    chk("col_ld_we", {31'd0, bus.write_enable}, 32'd1);
    chk("col_ld_addr", {27'd0, bus.addr_rd}, 32'd9);
    chk("col_ld_data", bus.data_rd, 32'hAABB_CCDD);
    chk("col_busy_clr", bus.busy, 32'd0);
    chk("col_err", {31'd0, bus.protocol_err}, 32'd0);

    // Full and overflow
    for (int i = 1; i <= 4; i++) begin
      issue(5'(i), 3'b010, 2'd0);
    end
    chk("full_flag", {31'd0, bus.ld_full}, 32'd1);
    chk("full_busy", bus.busy, 32'h0000_001E);
    chk("full_err0", {31'd0, bus.protocol_err}, 32'd0);
    issue(5'd5, 3'b010, 2'd0);
    chk("ovf_err", {31'd0, bus.protocol_err}, 32'd1);
    chk("ovf_busy", bus.busy, 32'h0000_001E);
    chk("ovf_full", {31'd0, bus.ld_full}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h100 + 32'(i);
      tick();
      if (i == 0) begin
        chk("drain_we0", {31'd0, bus.write_enable}, 32'd0);
      end else begin
        chk("drain_we", {31'd0, bus.write_enable}, 32'd1);
        chk("drain_addr", {27'd0, bus.addr_rd}, 32'(i));
        chk("drain_data", bus.data_rd, 32'h100 + 32'(i - 1));
      end
    end
    bus.mem_rvalid = 1'b0;
    tick();
    chk("drain_we4", {31'd0, bus.write_enable}, 32'd1);
    chk("drain_addr4", {27'd0, bus.addr_rd}, 32'd4);
    chk("drain_data4", bus.data_rd, 32'h103);
    chk("drain_busy", bus.busy, 32'd0);
    chk("drain_full", {31'd0, bus.ld_full}, 32'd0);

    // x0 load and unsolicited data
    do_reset();
    chk("x0_err_rst", {31'd0, bus.protocol_err}, 32'd0);
    issue(5'd0, 3'b010, 2'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hFFFF_FFFF;
    tick();
    bus.mem_rvalid = 1'b0;
    chk("x0_we_fill", {31'd0, bus.write_enable}, 32'd0);
    tick();
    chk("x0_we_sel", {31'd0, bus.write_enable}, 32'd0);
    chk("x0_err", {31'd0, bus.protocol_err}, 32'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h5555_5555;
    tick();
    bus.mem_rvalid = 1'b0;
    chk("unsol_err", {31'd0, bus.protocol_err}, 32'd1);
    chk("unsol_we", {31'd0, bus.write_enable}, 32'd0);
    tick();
    chk("unsol_we2", {31'd0, bus.write_enable}, 32'd0);

    // Reset mid-operation
    do_reset();
    issue(5'd10, 3'b010, 2'd0);
    issue(5'd11, 3'b010, 2'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h7777_7777;
    tick();
    bus.mem_rvalid = 1'b0;
    chk("mid_busy", bus.busy, 32'h0000_0C00);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("mid_busy_rst", bus.busy, 32'd0);
    chk("mid_we_rst", {31'd0, bus.write_enable}, 32'd0);
    chk("mid_err_rst", {31'd0, bus.protocol_err}, 32'd0);
    chk("mid_full_rst", {31'd0, bus.ld_full}, 32'd0);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h8888_8888;
    tick();
    bus.mem_rvalid = 1'b0;
    chk("late_err", {31'd0, bus.protocol_err}, 32'd1);
    tick();
    chk("late_we", {31'd0, bus.write_enable}, 32'd0);
    chk("late_busy", bus.busy, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
